// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter (CPU port C, loader port L) with a wait-state counter.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; otherwise the CPU always wins ties.
module mem_bus_arbiter #(
    parameter int AW   = 8,
    parameter int DW   = 16,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    output logic          c_stall,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_ack,
    output logic [DW-1:0] l_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy
);
    // A zero wait count still needs one strobe cycle.
    localparam int WEFF = (WAIT < 1) ? 1 : WAIT;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic          lat_we, lat_we_n;
    logic          last_owner, last_owner_n;
    logic          win;
    logic          c_ack_n, l_ack_n, mem_en_n, mem_we_n, owner_n, busy_n;
    logic [AW-1:0] mem_addr_n;
    logic [DW-1:0] mem_wdata_n, c_rdata_n, l_rdata_n;

    assign c_stall = c_req & ~c_ack;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        lat_we_n     = lat_we;
        last_owner_n = last_owner;
        owner_n      = owner;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        c_rdata_n    = c_rdata;
        l_rdata_n    = l_rdata;
        c_ack_n      = 1'b0;
        l_ack_n      = 1'b0;
        mem_en_n     = 1'b0;
        mem_we_n     = 1'b0;
        win          = 1'b0;
        case (state)
            IDLE: begin
                if (c_req || l_req) begin
                    if (c_req && l_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                        win = ~last_owner;
`else
                        win = 1'b0;
`endif
                    end else begin
                        win = l_req;
                    end
                    owner_n     = win;
                    lat_we_n    = win ? l_we : c_we;
                    mem_addr_n  = win ? l_addr : c_addr;
                    mem_wdata_n = win ? l_wdata : c_wdata;
                    cnt_n       = 4'(WEFF - 1);
                    mem_en_n    = 1'b1;
                    mem_we_n    = win ? l_we : c_we;
                    state_n     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_n    = cnt - 4'd1;
                    mem_en_n = 1'b1;
                    mem_we_n = lat_we;
                end else begin
                    // Last wait cycle: memory data is stable, capture it for the owner.
                    if (!lat_we) begin
                        if (owner) l_rdata_n = mem_rdata;
                        else       c_rdata_n = mem_rdata;
                    end
                    c_ack_n = ~owner;
                    l_ack_n = owner;
                    state_n = DONE;
                end
            end
            DONE: begin
                last_owner_n = owner;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            busy       <= 1'b0;
            c_ack      <= 1'b0;
            l_ack      <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            c_rdata    <= '0;
            l_rdata    <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            lat_we     <= lat_we_n;
            last_owner <= last_owner_n;
            owner      <= owner_n;
            busy       <= busy_n;
            c_ack      <= c_ack_n;
            l_ack      <= l_ack_n;
            mem_en     <= mem_en_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            c_rdata    <= c_rdata_n;
            l_rdata    <= l_rdata_n;
        end
    end
endmodule
